// File: rtl/cmp_sched_pkg.sv
// Shared definitions for cmp_sched: op codes, FSM encoding and the compare function.
package cmp_sched_pkg;

  localparam logic [2:0] OP_LE = 3'd0;
  localparam logic [2:0] OP_LT = 3'd1;
  localparam logic [2:0] OP_GE = 3'd2;
  localparam logic [2:0] OP_GT = 3'd3;
  localparam logic [2:0] OP_EQ = 3'd4;
  localparam logic [2:0] OP_NE = 3'd5;

  // Widest operand the compare function accepts; callers pre-extend narrower operands.
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  // Returns {err, result}. One extra bit of headroom makes the signed/unsigned compare uniform.
  function automatic logic [1:0] cmp_eval(input logic [MAX_W-1:0] a,
                                          input logic [MAX_W-1:0] b,
                                          input logic [2:0]       op,
                                          input logic             sgn);
    logic signed [MAX_W:0] ax;
    logic signed [MAX_W:0] bx;
    logic                  lt;
    logic                  eq;
    logic [1:0]            r;
    ax = {sgn & a[MAX_W-1], a};
    bx = {sgn & b[MAX_W-1], b};
    lt = (ax < bx);
    eq = (ax == bx);
    case (op)
      OP_LE:   r = {1'b0, lt | eq};
      OP_LT:   r = {1'b0, lt};
      OP_GE:   r = {1'b0, ~lt};
      OP_GT:   r = {1'b0, ~(lt | eq)};
      OP_EQ:   r = {1'b0, eq};
      OP_NE:   r = {1'b0, ~eq};
      default: r = 2'b10;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_sched_if.sv
// Request/response bundle between the requesters, the consumer and cmp_sched.
interface cmp_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ*3-1:0]     req_op;
  logic [N_REQ-1:0]       req_signed;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_result;
  logic                   rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, req_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );
endinterface

// File: rtl/cmp_sched_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping at N_REQ.
module cmp_sched_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  always_comb begin
    logic            found;
    int              idx;
    logic [ID_W-1:0] idx_v;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    idx_v    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_v = ID_W'(idx);
      if (!found && req[idx_v]) begin
        found        = 1'b1;
        grant[idx_v] = 1'b1;
        grant_id     = idx_v;
      end
    end
  end

endmodule

// File: rtl/cmp_sched.sv
// Shares one registered comparator among N_REQ requesters (IDLE -> CMP -> RESP).
// Optional hit/error counters are built when CMP_SCHED_STATS_EN is defined.
module cmp_sched
  import cmp_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  cmp_sched_if.slave       bus
`ifdef CMP_SCHED_STATS_EN
  ,
  output logic [15:0]      true_count,
  output logic [7:0]       err_count
`endif
);

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_id;
  logic [WIDTH-1:0]  a_p0;
  logic [WIDTH-1:0]  b_p0;
  logic [2:0]        op_p0;
  logic              sgn_p0;
  logic [1:0]        cmp_res;

  function automatic logic [MAX_W-1:0] ext(input logic [WIDTH-1:0] v, input logic s);
    logic [MAX_W-1:0] r;
    r = MAX_W'(v);
    for (int k = WIDTH; k < MAX_W; k++) r[k] = s & v[WIDTH-1];
    return r;
  endfunction

  cmp_sched_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req      (bus.req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Grant is visible only while idle and out of reset, so ready is never asserted during rst.
  assign bus.req_ready = (state == IDLE && !rst) ? grant : '0;
  assign ptr_nxt       = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  assign cmp_res       = cmp_eval(ext(a_p0, sgn_p0), ext(b_p0, sgn_p0), op_p0, sgn_p0);

  // Stage p0: operand capture at accept
  always_ff @(posedge clk) begin
    if (state == IDLE && |grant) begin
      a_p0   <= bus.req_a[int'(grant_id)*WIDTH +: WIDTH];
      b_p0   <= bus.req_b[int'(grant_id)*WIDTH +: WIDTH];
      op_p0  <= bus.req_op[int'(grant_id)*3 +: 3];
      sgn_p0 <= bus.req_signed[grant_id];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_result <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            ptr        <= ptr_nxt;
            bus.rsp_id <= grant_id;
            state      <= CMP;
          end
        end
        // Stage p1: compare result registered onto the response channel
        CMP: begin
          bus.rsp_result <= cmp_res[0];
          bus.rsp_err    <= cmp_res[1];
          bus.rsp_valid  <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMP_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      true_count <= '0;
      err_count  <= '0;
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      if (!bus.rsp_err && bus.rsp_result && true_count != 16'hFFFF)
        true_count <= true_count + 16'd1;
      if (bus.rsp_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
